// File: rtl/dmg_timer_pkg.sv
// Shared definitions for the DMG programmable timer (TIMA/TMA/TAC).
package dmg_timer_pkg;

  localparam logic [1:0] ADDR_DIV  = 2'b00;
  localparam logic [1:0] ADDR_TIMA = 2'b01;
  localparam logic [1:0] ADDR_TMA  = 2'b10;
  localparam logic [1:0] ADDR_TAC  = 2'b11;

  localparam logic [4:0] TAC_UNUSED_BITS = 5'b11111;

  typedef enum logic [1:0] {
    SEL_4096   = 2'd0,
    SEL_262144 = 2'd1,
    SEL_65536  = 2'd2,
    SEL_16384  = 2'd3
  } tac_sel_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    OVF    = 2'd1,
    RELOAD = 2'd2
  } timer_state_t;

  // Tick level for a given TAC: enable bit gates the selected divider tap.
  function automatic logic tap_tick(input logic [2:0] tac, input logic [3:0] taps);
    logic sel;
    case (tac_sel_t'(tac[1:0]))
      SEL_4096:   sel = taps[0];
      SEL_262144: sel = taps[1];
      SEL_65536:  sel = taps[2];
      SEL_16384:  sel = taps[3];
      default:    sel = 1'b0;
    endcase
    return tac[2] & sel;
  endfunction

endpackage

// File: rtl/dmg_timer_if.sv
// CPU register-bus view of the timer; master = CPU side, slave = timer.
interface dmg_timer_if;
  logic       ff04_ff07;
  logic [1:0] addr;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output ff04_ff07, addr, cpu_wr, cpu_rd, d_in, input d_out, d_oe);
  modport slave  (input ff04_ff07, addr, cpu_wr, cpu_rd, d_in, output d_out, d_oe);
endinterface

// File: rtl/dmg_timer_tick.sv
// Tap mux and falling-edge detector producing TIMA increment events.
// DMG_TIMER_TAC_GLITCH_EN: a TAC write that drops the tick counts as a falling edge.
module dmg_timer_tick
  import dmg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       m_ce,
  input  logic [3:0] div_tap,
  input  logic [2:0] tac,
  input  logic       tac_wr,
  input  logic [2:0] tac_new,
  output logic       inc_evt
);

  logic tick_prev_r;
  logic tick_s;
  logic tick_new_s;

  assign tick_s     = tap_tick(tac, div_tap);
  assign tick_new_s = tap_tick(tac_new, div_tap);

  // Increment event: falling tick on an M-cycle, with TAC-write handling.
  always_comb begin
    inc_evt = 1'b0;
    if (!m_ce) begin
      inc_evt = 1'b0;
    end else if (tac_wr) begin
`ifdef DMG_TIMER_TAC_GLITCH_EN
      inc_evt = (tick_prev_r & ~tick_s) | (tick_s & ~tick_new_s);
`else
      inc_evt = 1'b0;
`endif
    end else begin
      inc_evt = tick_prev_r & ~tick_s;
    end
  end

  // A TAC write rearms the detector with the tick level of the new selection.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_prev_r <= 1'b0;
    end else if (m_ce) begin
      tick_prev_r <= tac_wr ? tick_new_s : tick_s;
    end
  end

endmodule

// File: rtl/dmg_timer.sv
// DMG timer: TIMA counts tap falling edges, reloads from TMA after overflow, pulses irq_timer.
// Optional feature macro: DMG_TIMER_TAC_GLITCH_EN (see dmg_timer_tick).
module dmg_timer
  import dmg_timer_pkg::*;
#(
  parameter logic [2:0] TAC_RESET = 3'b000,
  parameter logic [7:0] TMA_RESET = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m_ce,
  input  logic [3:0] div_tap,
  dmg_timer_if.slave bus,
  output logic       irq_timer
);

  timer_state_t state_r;
  logic [7:0]   tima_r;
  logic [7:0]   tma_r;
  logic [2:0]   tac_r;
  logic         irq_r;
  logic         inc_evt_s;
  logic         wr_s;
  logic         wr_tima_s;
  logic         wr_tma_s;
  logic         wr_tac_s;

  assign wr_s      = m_ce & bus.cpu_wr & bus.ff04_ff07;
  assign wr_tima_s = wr_s & (bus.addr == ADDR_TIMA);
  assign wr_tma_s  = wr_s & (bus.addr == ADDR_TMA);
  assign wr_tac_s  = wr_s & (bus.addr == ADDR_TAC);
  assign irq_timer = irq_r;

  dmg_timer_tick u_tick (
    .clk     (clk),
    .reset   (reset),
    .m_ce    (m_ce),
    .div_tap (div_tap),
    .tac     (tac_r),
    .tac_wr  (wr_tac_s),
    .tac_new (bus.d_in[2:0]),
    .inc_evt (inc_evt_s)
  );

  // Register file plus RUN -> OVF -> RELOAD sequencing; irq_r spans the RELOAD M-cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tima_r  <= 8'h00;
      tma_r   <= TMA_RESET;
      tac_r   <= TAC_RESET;
      state_r <= RUN;
      irq_r   <= 1'b0;
    end else if (m_ce) begin
      if (wr_tma_s) tma_r <= bus.d_in;
      if (wr_tac_s) tac_r <= bus.d_in[2:0];
      case (state_r)
        RUN: begin
          irq_r <= 1'b0;
          if (wr_tima_s) begin
            tima_r <= bus.d_in;
          end else if (inc_evt_s) begin
            if (tima_r == 8'hFF) begin
              tima_r  <= 8'h00;
              state_r <= OVF;
            end else begin
              tima_r <= tima_r + 8'h01;
            end
          end
        end
        OVF: begin
          if (wr_tima_s) begin
            tima_r  <= bus.d_in;
            irq_r   <= 1'b0;
            state_r <= RUN;
          end else begin
            tima_r  <= wr_tma_s ? bus.d_in : tma_r;
            irq_r   <= 1'b1;
            state_r <= RELOAD;
          end
        end
        RELOAD: begin
          // TIMA follows a TMA write here; a direct TIMA write is dropped.
          if (wr_tma_s) tima_r <= bus.d_in;
          irq_r   <= 1'b0;
          state_r <= RUN;
        end
        default: begin
          irq_r   <= 1'b0;
          state_r <= RUN;
        end
      endcase
    end
  end

  // Combinational read mux; only FF05-FF07 drive the bus.
  always_comb begin
    bus.d_oe  = 1'b0;
    bus.d_out = 8'h00;
    if (bus.cpu_rd & bus.ff04_ff07) begin
      case (bus.addr)
        ADDR_TIMA: begin
          bus.d_oe  = 1'b1;
          bus.d_out = tima_r;
        end
        ADDR_TMA: begin
          bus.d_oe  = 1'b1;
          bus.d_out = tma_r;
        end
        ADDR_TAC: begin
          bus.d_oe  = 1'b1;
          bus.d_out = {TAC_UNUSED_BITS, tac_r};
        end
        default: begin
          bus.d_oe  = 1'b0;
          bus.d_out = 8'h00;
        end
      endcase
    end else begin
      bus.d_oe  = 1'b0;
      bus.d_out = 8'h00;
    end
  end

endmodule

// File: tb/tb_dmg_timer.sv
// Self-checking bench for dmg_timer; expected bytes queued at stimulus, popped at readback.
module tb_dmg_timer;
  import dmg_timer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       m_ce = 1'b0;
  logic [3:0] div_tap;
  logic       irq_timer;

  dmg_timer_if bus();

  int checks = 0;
  int errors = 0;
  int irq_clks = 0;
  int irq_base;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;
  logic [7:0] got_v;
  logic       oe_v;

  dmg_timer #(.TAC_RESET(3'b000), .TMA_RESET(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .m_ce      (m_ce),
    .div_tap   (div_tap),
    .bus       (bus),
    .irq_timer (irq_timer)
  );

  always #5 clk = ~clk;

  initial begin : mce_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      m_ce = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  always @(negedge clk) begin
    if (irq_timer === 1'b1) irq_clks <= irq_clks + 1;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic step();
    do @(posedge clk); while (m_ce !== 1'b1);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    bus.ff04_ff07 = 1'b1;
    bus.addr      = a;
    bus.d_in      = d;
    bus.cpu_wr    = 1'b1;
    step();
    bus.cpu_wr    = 1'b0;
    bus.ff04_ff07 = 1'b0;
  endtask

  task automatic bus_read(input logic sel, input logic [1:0] a, output logic [7:0] d, output logic o);
    bus.ff04_ff07 = sel;
    bus.addr      = a;
    bus.cpu_rd    = 1'b1;
    #1;
    d = bus.d_out;
    o = bus.d_oe;
    bus.cpu_rd    = 1'b0;
    bus.ff04_ff07 = 1'b0;
  endtask

  task automatic tap_period();
    div_tap = 4'b0010; step(); step();
    div_tap = 4'b0000; step(); step();
  endtask

  // Leaves the timer in OVF with TMA=F0, TIMA just wrapped from FF.
  task automatic setup_ovf();
    div_tap = 4'b0000;
    bus_write(ADDR_TAC, 8'h05);
    bus_write(ADDR_TMA, 8'hF0);
    bus_write(ADDR_TIMA, 8'hFF);
    div_tap = 4'b0010; step(); step();
    div_tap = 4'b0000; step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hF8);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_tima got=%h exp=%h", got_v, exp_v); end
    bus_read(1'b1, ADDR_TMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_tma got=%h exp=%h", got_v, exp_v); end
    bus_read(1'b1, ADDR_TAC, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reset_tac got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (irq_timer !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_timer); end
    step();
  endtask

  task automatic test_count();
    irq_base = irq_clks;
    div_tap = 4'b0000;
    bus_write(ADDR_TAC, 8'h05);
    for (int i = 1; i <= 10; i++) begin
      tap_period();
      exp_q.push_back(8'(i));
      bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
      exp_v = exp_q.pop_front(); checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL count_tima got=%h exp=%h", got_v, exp_v); end
    end
    checks++;
    if (irq_clks - irq_base !== 0) begin errors++; $display("FAIL count_irq got=%0d exp=0", irq_clks - irq_base); end
  endtask

  task automatic test_overflow();
    setup_ovf();
    irq_base = irq_clks;
    exp_q.push_back(8'h00);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ovf_tima got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (irq_timer !== 1'b0) begin errors++; $display("FAIL ovf_irq got=%b exp=0", irq_timer); end
    step();
    exp_q.push_back(8'hF0);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL reload_tima got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (irq_timer !== 1'b1) begin errors++; $display("FAIL reload_irq got=%b exp=1", irq_timer); end
    step();
    checks++;
    if (irq_clks - irq_base !== 4) begin errors++; $display("FAIL irq_width got=%0d exp=4", irq_clks - irq_base); end
    exp_q.push_back(8'hF0);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL run_tima got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_ovf_write();
    setup_ovf();
    irq_base = irq_clks;
    bus_write(ADDR_TIMA, 8'h33);
    step();
    exp_q.push_back(8'h33);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL ovfwr_tima got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (irq_clks - irq_base !== 0) begin errors++; $display("FAIL ovfwr_irq got=%0d exp=0", irq_clks - irq_base); end
  endtask

  task automatic test_reload_write();
    setup_ovf();
    irq_base = irq_clks;
    step();
    bus_write(ADDR_TMA, 8'h55);
    exp_q.push_back(8'h55); exp_q.push_back(8'h55);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rldtma_tima got=%h exp=%h", got_v, exp_v); end
    bus_read(1'b1, ADDR_TMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rldtma_tma got=%h exp=%h", got_v, exp_v); end
    checks++;
    if (irq_clks - irq_base !== 4) begin errors++; $display("FAIL rldtma_irq got=%0d exp=4", irq_clks - irq_base); end
    setup_ovf();
    step();
    bus_write(ADDR_TIMA, 8'h77);
    exp_q.push_back(8'hF0);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL rldtima_tima got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_read();
    bus_write(ADDR_TAC, 8'h06);
    exp_q.push_back(8'hFE);
    bus_read(1'b1, ADDR_TAC, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v || oe_v !== 1'b1) begin errors++; $display("FAIL read_tac got=%h/%b exp=%h/1", got_v, oe_v, exp_v); end
    exp_q.push_back(8'h00);
    bus_read(1'b1, ADDR_DIV, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v || oe_v !== 1'b0) begin errors++; $display("FAIL read_div got=%h/%b exp=%h/0", got_v, oe_v, exp_v); end
    exp_q.push_back(8'h00);
    bus_read(1'b0, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v || oe_v !== 1'b0) begin errors++; $display("FAIL read_nosel got=%h/%b exp=%h/0", got_v, oe_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    div_tap = 4'b0000;
    bus_write(ADDR_TAC, 8'h05);
    div_tap = 4'b0010; step(); step();
    div_tap = 4'b0000;
    bus_write(ADDR_TIMA, 8'h40);
    step();
    exp_q.push_back(8'h40);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL b2b_write got=%h exp=%h", got_v, exp_v); end
    tap_period();
    exp_q.push_back(8'h41);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL b2b_next got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_tac_glitch();
    div_tap = 4'b0010; step(); step();
    bus_write(ADDR_TAC, 8'h00);
`ifdef DMG_TIMER_TAC_GLITCH_EN
    exp_q.push_back(8'h42);
`else
    exp_q.push_back(8'h41);
`endif
    div_tap = 4'b0000; step(); step();
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL tac_glitch got=%h exp=%h", got_v, exp_v); end
  endtask

  task automatic test_reset_abort();
    setup_ovf();
    irq_base = irq_clks;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(); step(); step();
    checks++;
    if (irq_clks - irq_base !== 0) begin errors++; $display("FAIL abort_irq got=%0d exp=0", irq_clks - irq_base); end
    exp_q.push_back(8'h00); exp_q.push_back(8'hF8);
    bus_read(1'b1, ADDR_TIMA, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL abort_tima got=%h exp=%h", got_v, exp_v); end
    bus_read(1'b1, ADDR_TAC, got_v, oe_v);
    exp_v = exp_q.pop_front(); checks++;
    if (got_v !== exp_v) begin errors++; $display("FAIL abort_tac got=%h exp=%h", got_v, exp_v); end
  endtask

  initial begin
    reset         = 1'b1;
    div_tap       = 4'b0000;
    bus.ff04_ff07 = 1'b0;
    bus.addr      = 2'b00;
    bus.cpu_wr    = 1'b0;
    bus.cpu_rd    = 1'b0;
    bus.d_in      = 8'h00;
    test_reset();
    test_count();
    test_overflow();
    test_ovf_write();
    test_reload_write();
    test_read();
    test_back_to_back();
    test_tac_glitch();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
